// File: rtl/waveform_capture_engine_if.sv
// Bundles the sample, trigger-control and readout signals of the waveform capture engine.
interface waveform_capture_engine_if #(
  parameter int NUM_CH   = 2,
  parameter int SAMPLE_W = 14,
  parameter int DEPTH    = 1024
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH*SAMPLE_W-1:0] adc_data;
  logic [CH_W-1:0]            trig_src;
  logic                       trig_slope;
  logic [SAMPLE_W-1:0]        trig_level;
  logic [ADDR_W-1:0]          pretrig_len;
  logic                       arm;
  logic                       force_trig;
  logic [CH_W-1:0]            rd_ch;
  logic [ADDR_W-1:0]          rd_addr;
  logic [SAMPLE_W-1:0]        rd_data;
  logic                       busy;
  logic                       done;
  logic                       triggered;
  logic [15:0]                wave_count;
  logic [ADDR_W-1:0]          trig_addr;

  modport master (
    output adc_data, trig_src, trig_slope, trig_level, pretrig_len, arm, force_trig, rd_ch, rd_addr,
    input  rd_data, busy, done, triggered, wave_count, trig_addr
  );

  modport slave (
    input  adc_data, trig_src, trig_slope, trig_level, pretrig_len, arm, force_trig, rd_ch, rd_addr,
    output rd_data, busy, done, triggered, wave_count, trig_addr
  );
endinterface

// File: rtl/waveform_capture_engine.sv
// Multi-channel pre-trigger waveform recorder: per-channel circular RAMs, level/slope or forced
// trigger, and readout indexed from the oldest sample of the finished record.
module waveform_capture_engine #(
  parameter int NUM_CH   = 2,
  parameter int SAMPLE_W = 14,
  parameter int DEPTH    = 1024
) (
  input logic                       clk,
  input logic                       reset_n,
  waveform_capture_engine_if.slave  bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {IDLE, PRE, WAIT_TRIG, POST, DONE} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   start_q, start_d;
  logic [ADDR_W-1:0]   trig_addr_q, trig_addr_d;
  logic [ADDR_W-1:0]   pre_len_q, pre_len_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [SAMPLE_W-1:0] prev_q, prev_d;
  logic [SAMPLE_W-1:0] rd_data_q, rd_data_d;
  logic                triggered_q, triggered_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [15:0]         wave_count_q, wave_count_d;

  logic                wr_en_s;
  logic [CH_W-1:0]     trig_sel_s;
  logic [CH_W-1:0]     rd_sel_s;
  logic [SAMPLE_W-1:0] cur_s;
  logic                level_hit_s;
  logic                trig_hit_s;
  logic [ADDR_W-1:0]   rd_idx_s;

  logic [SAMPLE_W-1:0] mem [NUM_CH][DEPTH];

  // Out-of-range channel selects fall back to channel 0.
  always_comb begin
    trig_sel_s  = (int'(bus.trig_src) < NUM_CH) ? bus.trig_src : {CH_W{1'b0}};
    rd_sel_s    = (int'(bus.rd_ch) < NUM_CH) ? bus.rd_ch : {CH_W{1'b0}};
    cur_s       = bus.adc_data[int'(trig_sel_s)*SAMPLE_W +: SAMPLE_W];
    if (bus.trig_slope) begin
      level_hit_s = (prev_q < bus.trig_level) && (cur_s >= bus.trig_level);
    end else begin
      level_hit_s = (prev_q > bus.trig_level) && (cur_s <= bus.trig_level);
    end
    trig_hit_s  = level_hit_s | bus.force_trig;
    rd_idx_s    = start_q + bus.rd_addr;
    rd_data_d   = mem[rd_sel_s][rd_idx_s];
  end

  // Next-state logic for the record FSM and its pointers/counters.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    start_d      = start_q;
    trig_addr_d  = trig_addr_q;
    pre_len_d    = pre_len_q;
    cnt_d        = cnt_q;
    triggered_d  = triggered_q;
    wave_count_d = wave_count_q;
    prev_d       = cur_s;
    wr_en_s      = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (bus.arm) begin
          // pretrig_len is ADDR_W wide, so it can never exceed DEPTH-1.
          pre_len_d   = bus.pretrig_len;
          triggered_d = 1'b0;
          cnt_d       = {ADDR_W{1'b0}};
          state_d     = (bus.pretrig_len == {ADDR_W{1'b0}}) ? WAIT_TRIG : PRE;
        end else begin
          state_d = state_q;
        end
      end
      PRE: begin
        wr_en_s  = 1'b1;
        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        if (cnt_q + ADDR_W'(1) == pre_len_q) begin
          cnt_d   = {ADDR_W{1'b0}};
          state_d = WAIT_TRIG;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      WAIT_TRIG: begin
        wr_en_s  = 1'b1;
        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        if (trig_hit_s) begin
          trig_addr_d = wr_ptr_q;
          start_d     = wr_ptr_q - pre_len_q;
          triggered_d = 1'b1;
          cnt_d       = {ADDR_W{1'b0}};
          // A full-length pre-trigger leaves no room for post-trigger samples.
          if (pre_len_q == LAST_IDX) begin
            state_d      = DONE;
            wave_count_d = wave_count_q + 16'd1;
          end else begin
            state_d = POST;
          end
        end else begin
          state_d = WAIT_TRIG;
        end
      end
      POST: begin
        wr_en_s  = 1'b1;
        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        if (cnt_q + ADDR_W'(1) == LAST_IDX - pre_len_q) begin
          state_d      = DONE;
          wave_count_d = wave_count_q + 16'd1;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == PRE) || (state_d == WAIT_TRIG) || (state_d == POST);
    done_d = (state_d == DONE);
  end

  // Control and status registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      wr_ptr_q     <= {ADDR_W{1'b0}};
      start_q      <= {ADDR_W{1'b0}};
      trig_addr_q  <= {ADDR_W{1'b0}};
      pre_len_q    <= {ADDR_W{1'b0}};
      cnt_q        <= {ADDR_W{1'b0}};
      prev_q       <= {SAMPLE_W{1'b0}};
      rd_data_q    <= {SAMPLE_W{1'b0}};
      triggered_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      wave_count_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      start_q      <= start_d;
      trig_addr_q  <= trig_addr_d;
      pre_len_q    <= pre_len_d;
      cnt_q        <= cnt_d;
      prev_q       <= prev_d;
      rd_data_q    <= rd_data_d;
      triggered_q  <= triggered_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      wave_count_q <= wave_count_d;
    end
  end

  // Sample RAMs: every channel is written at the shared write pointer.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      for (int k = 0; k < NUM_CH; k++) begin
        mem[k][wr_ptr_q] <= bus.adc_data[k*SAMPLE_W +: SAMPLE_W];
      end
    end
  end

  assign bus.rd_data    = rd_data_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.triggered  = triggered_q;
  assign bus.wave_count = wave_count_q;
  assign bus.trig_addr  = trig_addr_q;
endmodule

// File: tb/tb_waveform_capture_engine.sv
// Directed bench for waveform_capture_engine with NUM_CH=2, SAMPLE_W=14, DEPTH=16.
module tb_waveform_capture_engine;
  logic clk;
  logic reset_n;
  int   n_pass;
  int   n_total;

  waveform_capture_engine_if #(.NUM_CH(2), .SAMPLE_W(14), .DEPTH(16)) bus ();

  waveform_capture_engine #(.NUM_CH(2), .SAMPLE_W(14), .DEPTH(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic drive(input int c0, input int c1, input logic a, input logic f);
    bus.adc_data   = {14'(c1), 14'(c0)};
    bus.arm        = a;
    bus.force_trig = f;
  endtask

  task automatic rd_chk(input int ch, input int addr, input int exp, input string tag);
    bus.rd_ch   = 1'(ch);
    bus.rd_addr = 4'(addr);
    tick;
    chk($sformatf("%s[%0d]", tag, addr), 32'(bus.rd_data), 32'(exp));
  endtask

  task automatic setup(input int src, input logic slope, input int level, input int pre);
    bus.trig_src    = 1'(src);
    bus.trig_slope  = slope;
    bus.trig_level  = 14'(level);
    bus.pretrig_len = 4'(pre);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    reset_n = 1'b0;
    drive(0, 0, 1'b0, 1'b0);
    setup(0, 1'b1, 0, 0);
    bus.rd_ch   = 1'b0;
    bus.rd_addr = 4'd0;
    tick;
    tick;
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_trig", 32'(bus.triggered), 0);
    chk("rst_wcnt", 32'(bus.wave_count), 0);
    chk("rst_taddr", 32'(bus.trig_addr), 0);
    chk("rst_rd", 32'(bus.rd_data), 0);
    reset_n = 1'b1;
    tick;

    // Rising trigger on a ch1 ramp, pretrig 4: trigger on sample 1000 at addr 9.
    setup(1, 1'b1, 1000, 4);
    for (int k = 0; k <= 21; k++) begin
      drive(k + 7, 100 * k, k == 0, 1'b0);
      tick;
      if (k == 0) chk("t1_busy_arm", 32'(bus.busy), 1);
      if (k == 9) chk("t1_pre_trig", 32'(bus.triggered), 0);
      if (k == 10) chk("t1_trig", 32'(bus.triggered), 1);
      if (k == 20) chk("t1_not_done", 32'(bus.done), 0);
    end
    drive(0, 0, 1'b0, 1'b0);
    chk("t1_done", 32'(bus.done), 1);
    chk("t1_idle", 32'(bus.busy), 0);
    chk("t1_wcnt", 32'(bus.wave_count), 1);
    chk("t1_taddr", 32'(bus.trig_addr), 9);
    for (int i = 0; i < 16; i++) rd_chk(1, i, 100 * (i + 6), "t1_ch1");
    for (int i = 0; i < 16; i++) rd_chk(0, i, 13 + i, "t1_ch0");

    // Falling trigger on ch0: rising crossing and flat low level must not fire.
    setup(0, 1'b0, 8192, 2);
    for (int j = 0; j <= 22; j++) begin
      drive((j >= 6 && j <= 8) ? 9400 : 7000, 200 + j, j == 0, 1'b0);
      tick;
      if (j == 0) chk("t2_trig_clr", 32'(bus.triggered), 0);
      if (j == 0) chk("t2_done_clr", 32'(bus.done), 0);
      if (j == 6) chk("t2_rise_ign", 32'(bus.triggered), 0);
      if (j == 8) chk("t2_high_ign", 32'(bus.triggered), 0);
      if (j == 9) chk("t2_trig", 32'(bus.triggered), 1);
      if (j == 9) chk("t2_taddr", 32'(bus.trig_addr), 13);
      if (j == 21) chk("t2_busy", 32'(bus.busy), 1);
    end
    drive(0, 0, 1'b0, 1'b0);
    chk("t2_done", 32'(bus.done), 1);
    chk("t2_wcnt", 32'(bus.wave_count), 2);
    for (int i = 0; i < 16; i++) rd_chk(0, i, (i < 2) ? 9400 : 7000, "t2_ch0");
    for (int i = 0; i < 16; i++) rd_chk(1, i, 207 + i, "t2_ch1");

    // Zero pretrig with force on the third WAIT_TRIG cycle.
    setup(0, 1'b1, 16383, 0);
    for (int j = 0; j <= 18; j++) begin
      drive(1000 + j, 3000 + j, j == 0, j == 3);
      tick;
      if (j == 0) chk("t3_busy", 32'(bus.busy), 1);
      if (j == 2) chk("t3_no_trig", 32'(bus.triggered), 0);
      if (j == 3) chk("t3_trig", 32'(bus.triggered), 1);
      if (j == 3) chk("t3_taddr", 32'(bus.trig_addr), 13);
      if (j == 17) chk("t3_busy_15", 32'(bus.busy), 1);
    end
    drive(0, 0, 1'b0, 1'b0);
    chk("t3_busy_16", 32'(bus.busy), 0);
    chk("t3_done", 32'(bus.done), 1);
    chk("t3_wcnt", 32'(bus.wave_count), 3);
    for (int i = 0; i < 16; i++) rd_chk(0, i, 1003 + i, "t3_ch0");
    rd_chk(1, 0, 3003, "t3_ch1");
    rd_chk(1, 15, 3018, "t3_ch1");

    // Full-length pretrig (15) starting at write pointer 13, wrapping the RAM.
    setup(1, 1'b1, 5000, 15);
    for (int j = 0; j <= 17; j++) begin
      drive(500 + j, (j < 17) ? 4000 : 6000, j == 0, 1'b0);
      tick;
      if (j == 16) chk("t4_busy", 32'(bus.busy), 1);
      if (j == 16) chk("t4_no_trig", 32'(bus.triggered), 0);
    end
    drive(0, 0, 1'b0, 1'b0);
    chk("t4_done", 32'(bus.done), 1);
    chk("t4_idle", 32'(bus.busy), 0);
    chk("t4_trig", 32'(bus.triggered), 1);
    chk("t4_taddr", 32'(bus.trig_addr), 13);
    chk("t4_wcnt", 32'(bus.wave_count), 4);
    for (int i = 0; i < 16; i++) rd_chk(0, i, 502 + i, "t4_ch0");
    rd_chk(1, 14, 4000, "t4_ch1");
    rd_chk(1, 15, 6000, "t4_ch1");

    // Arm pulses in PRE, POST and on the final POST write are all ignored.
    setup(0, 1'b1, 1000, 3);
    for (int j = 0; j <= 17; j++) begin
      drive((j < 4) ? 100 * j : 1000 + 100 * (j - 4), 50 + j,
            (j == 0) || (j == 2) || (j == 10) || (j == 16), 1'b0);
      tick;
      if (j == 4) chk("t5_trig", 32'(bus.triggered), 1);
      if (j == 4) chk("t5_taddr", 32'(bus.trig_addr), 1);
      if (j == 15) chk("t5_busy", 32'(bus.busy), 1);
      if (j == 16) chk("t5_done", 32'(bus.done), 1);
      if (j == 17) chk("t5_done_hold", 32'(bus.done), 1);
      if (j == 17) chk("t5_idle_hold", 32'(bus.busy), 0);
    end
    drive(0, 0, 1'b0, 1'b0);
    chk("t5_wcnt", 32'(bus.wave_count), 5);
    for (int i = 0; i < 16; i++) rd_chk(0, i, (i < 3) ? 100 * (i + 1) : 1000 + 100 * (i - 3), "t5_ch0");
    for (int i = 0; i < 16; i += 5) rd_chk(1, i, 51 + i, "t5_ch1");

    // Asynchronous reset in the middle of POST.
    setup(0, 1'b1, 16383, 2);
    for (int j = 0; j <= 6; j++) begin
      drive(10 + j, 20 + j, j == 0, j == 3);
      tick;
      if (j == 3) chk("t6_pre_trig", 32'(bus.triggered), 1);
      if (j == 6) chk("t6_pre_busy", 32'(bus.busy), 1);
    end
    drive(0, 0, 1'b0, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_busy", 32'(bus.busy), 0);
    chk("t6_rst_done", 32'(bus.done), 0);
    chk("t6_rst_trig", 32'(bus.triggered), 0);
    chk("t6_rst_wcnt", 32'(bus.wave_count), 0);
    chk("t6_rst_taddr", 32'(bus.trig_addr), 0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int j = 0; j <= 17; j++) begin
      drive(10 + j, 20 + j, j == 0, j == 4);
      tick;
      if (j == 3) chk("t6_no_trig", 32'(bus.triggered), 0);
      if (j == 4) chk("t6_trig", 32'(bus.triggered), 1);
      if (j == 4) chk("t6_taddr", 32'(bus.trig_addr), 3);
      if (j == 16) chk("t6_busy", 32'(bus.busy), 1);
    end
    drive(0, 0, 1'b0, 1'b0);
    chk("t6_done", 32'(bus.done), 1);
    chk("t6_wcnt", 32'(bus.wave_count), 1);
    for (int i = 0; i < 16; i++) rd_chk(0, i, 12 + i, "t6_ch0");
    rd_chk(1, 2, 24, "t6_ch1");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
